branch_redirect_ctrl: RTL and testbench

//   Sequences resolution of one RV32I conditional branch at a time. Takes the

---
 rtl/branch_redirect_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Resolves one RV32I conditional branch at a time: evaluate, redirect fetch, flush, retire.
// Misaligned taken targets raise a one-cycle exception instead of redirecting.

package branch_redirect_pkg;
    typedef enum logic [2:0] {
        bk_invalid = 3'd0,
        bk_beq     = 3'd1,
        bk_bne     = 3'd2,
        bk_blt     = 3'd3,
        bk_bge     = 3'd4,
        bk_bltu    = 3'd5,
        bk_bgeu    = 3'd6
    } branch_kind_t;
endpackage

module branch_redirect_ctrl
    import branch_redirect_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  branch_kind_t    br_kind,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic            done_valid,
    output logic            done_taken
);

    // state    | meaning
    // S_IDLE   | waiting for a branch request, br_ready high
    // S_EVAL   | condition evaluated on captured operands
    // S_REDIRECT | redirect offered to fetch until redir_ready
    // S_FLUSH  | flush held for FLUSH_CYCLES, done on the last one
    // S_EXC    | one-cycle misaligned-target exception
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EVAL     = 3'd1,
        S_REDIRECT = 3'd2,
        S_FLUSH    = 3'd3,
        S_EXC      = 3'd4
    } state_t;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("branch_redirect_ctrl: FLUSH_CYCLES must be at least 1");
    end
    if (XLEN < 2) begin : g_bad_xlen
        $error("branch_redirect_ctrl: XLEN must be at least 2");
    end

    state_t          state;
    state_t          state_next;
    branch_kind_t    kind_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] target_q;
    logic [CW-1:0]   flush_cnt;
    logic            out_en;
    logic            nt_done;
    logic            taken;
    logic            accept;
    logic            misaligned;

    // out_en keeps every output low in the cycle right after a reset edge
    assign accept     = br_valid && out_en && (state == S_IDLE);
    assign misaligned = (target_q[1:0] != 2'b00);

    always_comb begin
        taken = 1'b0;
        case (kind_q)
            bk_beq:  taken = (rs1_q == rs2_q);
            bk_bne:  taken = (rs1_q != rs2_q);
            bk_blt:  taken = ($signed(rs1_q) <  $signed(rs2_q));
            bk_bge:  taken = ($signed(rs1_q) >= $signed(rs2_q));
            bk_bltu: taken = (rs1_q <  rs2_q);
            bk_bgeu: taken = (rs1_q >= rs2_q);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!taken) begin
                    state_next = S_IDLE;
                end else if (misaligned) begin
                    state_next = S_EXC;
                end else begin
                    state_next = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redir_ready) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            S_EXC:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q    <= bk_invalid;
            rs1_q     <= '0;
            rs2_q     <= '0;
            target_q  <= '0;
            flush_cnt <= '0;
            out_en    <= 1'b0;
            nt_done   <= 1'b0;
        end else begin
            out_en  <= 1'b1;
            nt_done <= (state == S_EVAL) && !taken;
            if (accept) begin
                kind_q   <= br_kind;
                rs1_q    <= br_rs1;
                rs2_q    <= br_rs2;
                target_q <= br_pc + br_imm;
            end
            if ((state == S_REDIRECT) && redir_ready) begin
                flush_cnt <= FLUSH_LAST;
            end else if ((state == S_FLUSH) && (flush_cnt != '0)) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        br_ready      = 1'b0;
        redir_valid   = 1'b0;
        redir_pc      = '0;
        flush         = 1'b0;
        misalign_exc  = 1'b0;
        misalign_addr = '0;
        done_valid    = 1'b0;
        done_taken    = 1'b0;
        if (out_en) begin
            case (state)
                S_IDLE: begin
                    br_ready   = 1'b1;
                    done_valid = nt_done;
                end
                S_REDIRECT: begin
                    redir_valid = 1'b1;
                    redir_pc    = target_q;
                end
                S_FLUSH: begin
                    flush      = 1'b1;
                    done_valid = (flush_cnt == '0);
                    done_taken = (flush_cnt == '0);
                end
                S_EXC: begin
                    misalign_exc  = 1'b1;
                    misalign_addr = target_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: table of branches with hand-computed
// outcomes plus reset-abandon and stall sequences.

module tb_branch_redirect_ctrl;
    import branch_redirect_pkg::*;

    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int O_NT  = 0;
    localparam int O_RED = 1;
    localparam int O_EXC = 2;

    typedef struct {
        branch_kind_t kind;
        logic [31:0]  pc;
        logic [31:0]  imm;
        logic [31:0]  rs1;
        logic [31:0]  rs2;
        int           delay;
        bit           hold;
        int           outcome;
        logic [31:0]  addr;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_valid;
    logic            br_ready;
    branch_kind_t    br_kind;
    logic [XLEN-1:0] br_pc, br_imm, br_rs1, br_rs2;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;
    logic            done_valid;
    logic            done_taken;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t vecs[13];

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .flush(flush), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
        .done_valid(done_valid), .done_taken(done_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // redirect, flush and exception must never overlap
    always @(negedge clk) begin
        if (!rst) begin
            check("mutex", 32'($countones({redir_valid, flush, misalign_exc}) > 1), 32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_br_ready"}, br_ready, 0);
        check({tag, "_redir_valid"}, redir_valid, 0);
        check({tag, "_redir_pc"}, redir_pc, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_exc"}, misalign_exc, 0);
        check({tag, "_exc_addr"}, misalign_addr, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        check({tag, "_done_taken"}, done_taken, 0);
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        int guard;
        string t;
        t = $sformatf("v%0d", idx);
        guard = 0;
        while (br_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({t, "_ready_wait"}, br_ready, 1);
        br_valid = 1'b1;
        br_kind  = v.kind;
        br_pc    = v.pc;
        br_imm   = v.imm;
        br_rs1   = v.rs1;
        br_rs2   = v.rs2;
        redir_ready = 1'b0;
        @(posedge clk);
        #1;
        if (!v.hold) br_valid = 1'b0;
        @(negedge clk);
        check({t, "_eval_ready"}, br_ready, 0);
        check({t, "_eval_redir"}, redir_valid, 0);
        check({t, "_eval_done"}, done_valid, 0);
        @(negedge clk);
        case (v.outcome)
            O_NT: begin
                check({t, "_nt_done"}, done_valid, 1);
                check({t, "_nt_taken"}, done_taken, 0);
                check({t, "_nt_redir"}, redir_valid, 0);
                check({t, "_nt_flush"}, flush, 0);
                check({t, "_nt_exc"}, misalign_exc, 0);
                check({t, "_nt_ready"}, br_ready, 1);
            end
            O_EXC: begin
                check({t, "_exc"}, misalign_exc, 1);
                check({t, "_exc_addr"}, misalign_addr, v.addr);
                check({t, "_exc_done"}, done_valid, 0);
                @(negedge clk);
                check({t, "_exc_pulse"}, misalign_exc, 0);
                check({t, "_exc_after_done"}, done_valid, 0);
                check({t, "_exc_after_ready"}, br_ready, 1);
            end
            default: begin
                for (int i = 0; i <= v.delay; i++) begin
                    check({t, "_redir_valid"}, redir_valid, 1);
                    check({t, "_redir_pc"}, redir_pc, v.addr);
                    check({t, "_redir_ready_out"}, br_ready, 0);
                    check({t, "_redir_done"}, done_valid, 0);
                    redir_ready = (i == v.delay);
                    @(negedge clk);
                end
                redir_ready = 1'b0;
                for (int f = 0; f < FC; f++) begin
                    check({t, "_flush"}, flush, 1);
                    check({t, "_flush_redir"}, redir_valid, 0);
                    check({t, "_flush_done"}, done_valid, 32'(f == FC - 1));
                    check({t, "_flush_taken"}, done_taken, 32'(f == FC - 1));
                    if (f == FC - 1) br_valid = 1'b0;
                    @(negedge clk);
                end
                check({t, "_post_flush"}, flush, 0);
                check({t, "_post_done"}, done_valid, 0);
                check({t, "_post_ready"}, br_ready, 1);
            end
        endcase
    endtask

    initial begin
        vecs[0]  = '{bk_beq,  32'h100,      32'h20,       32'd5,        32'd5,        0, 1'b0, O_RED, 32'h120};
        vecs[1]  = '{bk_blt,  32'h200,      32'h40,       32'hFFFFFFFF, 32'd1,        0, 1'b0, O_RED, 32'h240};
        vecs[2]  = '{bk_bltu, 32'h200,      32'h40,       32'hFFFFFFFF, 32'd1,        0, 1'b0, O_NT,  32'h0};
        vecs[3]  = '{bk_bgeu, 32'hFFFFFFF0, 32'h20,       32'd7,        32'd7,        0, 1'b0, O_RED, 32'h10};
        vecs[4]  = '{bk_bne,  32'h100,      32'h6,        32'd1,        32'd2,        0, 1'b0, O_EXC, 32'h106};
        vecs[5]  = '{bk_bge,  32'h1000,     32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 0, 1'b0, O_RED, 32'hFF8};
        vecs[6]  = '{bk_bgeu, 32'h1000,     32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 0, 1'b0, O_NT,  32'h0};
        vecs[7]  = '{bk_beq,  32'h100,      32'h20,       32'd1,        32'd2,        0, 1'b0, O_NT,  32'h0};
        vecs[8]  = '{bk_bne,  32'h100,      32'h20,       32'd4,        32'd4,        0, 1'b0, O_NT,  32'h0};
        vecs[9]  = '{bk_blt,  32'h0,        32'h10,       32'h80000000, 32'h7FFFFFFF, 5, 1'b1, O_RED, 32'h10};
        vecs[10] = '{bk_blt,  32'h300,      32'h8,        32'd5,        32'd5,        0, 1'b0, O_NT,  32'h0};
        vecs[11] = '{bk_bge,  32'h300,      32'h2,        32'd5,        32'd5,        0, 1'b0, O_EXC, 32'h302};
        vecs[12] = '{branch_kind_t'(3'd7), 32'h100, 32'h20, 32'd5,     32'd5,        0, 1'b0, O_NT,  32'h0};

        rst = 1'b1;
        br_valid = 1'b0;
        br_kind = bk_invalid;
        br_pc = '0;
        br_imm = '0;
        br_rs1 = '0;
        br_rs2 = '0;
        redir_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_ready", br_ready, 1);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // reset while a redirect is waiting for fetch abandons the branch
        @(negedge clk);
        br_valid = 1'b1;
        br_kind  = bk_beq;
        br_pc    = 32'h400;
        br_imm   = 32'h8;
        br_rs1   = 32'd9;
        br_rs2   = 32'd9;
        redir_ready = 1'b0;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_redir_valid", redir_valid, 1);
        check("rstmid_redir_pc", redir_pc, 32'h408);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstmid");
        rst = 1'b0;
        redir_ready = 1'b1;
        @(negedge clk);
        check("rstmid_ready", br_ready, 1);
        for (int c = 0; c < 4; c++) begin
            check("rstmid_no_redir", redir_valid, 0);
            check("rstmid_no_flush", flush, 0);
            check("rstmid_no_done", done_valid, 0);
            check("rstmid_no_exc", misalign_exc, 0);
            @(negedge clk);
        end
        redir_ready = 1'b0;
        run_vec('{bk_invalid, 32'h100, 32'h20, 32'd5, 32'd5, 0, 1'b0, O_NT, 32'h0}, 99);

        // back-to-back: new request accepted in the cycle a not-taken branch retires
        run_vec(vecs[2], 100);
        run_vec(vecs[0], 101);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
